// File: rtl/rob.sv
// Reorder buffer: in-order issue/commit window over an out-of-order CDB.
// Tags 1..ROB_SZ name entries; tag 0 means "no producer".
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global stall; all state holds while low
//   issue_*             allocate the entry at tail (tail = its tag)
//   full                no free entry (count == ROB_SZ)
//   cdb_*               result broadcast; marks a busy entry ready
//   rs1_id, rs2_id      operand producer tags to look up
//   rob_rsN_ready/value operand lookup results
//   commit_*, head      retirement of the oldest entry
//   flush, flush_pc     branch mispredict squash and redirect PC
//
// Config macro ROB_CDB_BYPASS_EN: when defined, operand lookups also
// see a same-cycle CDB broadcast; otherwise only stored state.
module rob #(
    parameter int ROB_SZ = 16,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic             issue_rd_hv,
    input  logic [4:0]       issue_rd,
    input  logic             issue_is_br,
    input  logic             issue_pred_taken,
    output logic             full,
    output logic [TAG_W-1:0] tail,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_br_taken,
    input  logic [31:0]      cdb_br_target,
    input  logic [TAG_W-1:0] rs1_id,
    input  logic [TAG_W-1:0] rs2_id,
    output logic             rob_rs1_ready,
    output logic [31:0]      rob_rs1_value,
    output logic             rob_rs2_ready,
    output logic [31:0]      rob_rs2_value,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [TAG_W-1:0] head,
    output logic             flush,
    output logic [31:0]      flush_pc
);

    localparam int CNT_W = $clog2(ROB_SZ + 1);
    localparam logic [TAG_W-1:0] FIRST = TAG_W'(1);
    localparam logic [TAG_W-1:0] LAST  = TAG_W'(ROB_SZ);
    localparam logic [CNT_W-1:0] CAP   = CNT_W'(ROB_SZ);

    // Slot 0 exists only so tags index directly; it is never written.
    logic [ROB_SZ:0] busy_q;
    logic [ROB_SZ:0] ready_q;
    logic [ROB_SZ:0] rd_hv_q;
    logic [ROB_SZ:0] is_br_q;
    logic [ROB_SZ:0] pred_q;
    logic [ROB_SZ:0] act_q;
    logic [4:0]      rd_q     [0:ROB_SZ];
    logic [31:0]     value_q  [0:ROB_SZ];
    logic [31:0]     target_q [0:ROB_SZ];

    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic issue_ok;
    logic cdb_ok;

    function automatic logic in_rng(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= LAST);
    endfunction

    function automatic logic [TAG_W-1:0] step(input logic [TAG_W-1:0] t);
        return (t == LAST) ? FIRST : t + FIRST;
    endfunction

    assign head = head_q;
    assign tail = tail_q;
    assign full = (count_q == CAP);

    assign commit_valid = !rst && rdy && busy_q[head_q] && ready_q[head_q];
    assign commit_rd    = rd_hv_q[head_q] ? rd_q[head_q] : 5'd0;
    assign commit_value = value_q[head_q];

    // The CDB stores either the taken target or PC+4 in target, so the
    // redirect is simply the stored target.
    assign flush    = commit_valid && is_br_q[head_q]
                      && (act_q[head_q] != pred_q[head_q]);
    assign flush_pc = target_q[head_q];

    assign issue_ok = issue_valid && !full && rdy && !flush;
    assign cdb_ok   = rdy && !flush && cdb_valid && in_rng(cdb_tag)
                      && busy_q[cdb_tag];

    always_comb begin
        rob_rs1_ready = 1'b0;
        rob_rs1_value = '0;
        rob_rs2_ready = 1'b0;
        rob_rs2_value = '0;
        if (!rst && in_rng(rs1_id)) begin
            rob_rs1_ready = busy_q[rs1_id] && ready_q[rs1_id];
            rob_rs1_value = value_q[rs1_id];
        end
        if (!rst && in_rng(rs2_id)) begin
            rob_rs2_ready = busy_q[rs2_id] && ready_q[rs2_id];
            rob_rs2_value = value_q[rs2_id];
        end
`ifdef ROB_CDB_BYPASS_EN
        if (!rst && cdb_valid && rs1_id != '0 && cdb_tag == rs1_id) begin
            rob_rs1_ready = 1'b1;
            rob_rs1_value = cdb_value;
        end
        if (!rst && cdb_valid && rs2_id != '0 && cdb_tag == rs2_id) begin
            rob_rs2_ready = 1'b1;
            rob_rs2_value = cdb_value;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= FIRST;
            tail_q  <= FIRST;
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
        end else if (rdy) begin
            if (flush) begin
                head_q  <= FIRST;
                tail_q  <= FIRST;
                count_q <= '0;
                busy_q  <= '0;
                ready_q <= '0;
            end else begin
                if (issue_ok) begin
                    busy_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]  <= 1'b0;
                    rd_hv_q[tail_q]  <= issue_rd_hv;
                    rd_q[tail_q]     <= issue_rd;
                    is_br_q[tail_q]  <= issue_is_br;
                    pred_q[tail_q]   <= issue_pred_taken;
                    act_q[tail_q]    <= 1'b0;
                    tail_q           <= step(tail_q);
                end
                if (cdb_ok) begin
                    ready_q[cdb_tag]  <= 1'b1;
                    value_q[cdb_tag]  <= cdb_value;
                    act_q[cdb_tag]    <= cdb_br_taken;
                    target_q[cdb_tag] <= cdb_br_target;
                end
                // Placed last so retirement wins over any same-slot write.
                if (commit_valid) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= step(head_q);
                end
                if (issue_ok && !commit_valid)
                    count_q <= count_q + CNT_W'(1);
                else if (!issue_ok && commit_valid)
                    count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: stimulus pushes expected commits, a
// negedge monitor pops and checks them whenever commit_valid is high.
module tb_rob;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_rd_hv, issue_is_br, issue_pred_taken;
    logic [4:0]  issue_rd;
    logic        full;
    logic [4:0]  tail, head;
    logic        cdb_valid, cdb_br_taken;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value, cdb_br_target;
    logic [4:0]  rs1_id, rs2_id;
    logic        rob_rs1_ready, rob_rs2_ready;
    logic [31:0] rob_rs1_value, rob_rs2_value;
    logic        commit_valid, flush;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value, flush_pc;

`ifdef ROB_CDB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    rob #(.ROB_SZ(16), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd_hv(issue_rd_hv),
        .issue_rd(issue_rd), .issue_is_br(issue_is_br),
        .issue_pred_taken(issue_pred_taken),
        .full(full), .tail(tail),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_br_taken(cdb_br_taken), .cdb_br_target(cdb_br_target),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs1_value(rob_rs1_value),
        .rob_rs2_ready(rob_rs2_ready), .rob_rs2_value(rob_rs2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_value(commit_value), .head(head),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [4:0]  hd;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val,
                        input logic [4:0] hd, input logic fl,
                        input logic [31:0] fpc);
        exp_t e;
        e.rd = rd; e.val = val; e.hd = hd; e.fl = fl; e.fpc = fpc;
        q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && commit_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: head %0d rd %0d, none expected",
                         head, commit_rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_rd", commit_rd, e.rd);
                chk("commit_value", commit_value, e.val);
                chk("commit_head", head, e.hd);
                chk("commit_flush", flush, e.fl);
                if (e.fl) chk("flush_pc", flush_pc, e.fpc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        issue_valid = 0; issue_rd_hv = 0; issue_rd = 0;
        issue_is_br = 0; issue_pred_taken = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        cdb_br_taken = 0; cdb_br_target = 0;
        rs1_id = 0; rs2_id = 0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_head", head, 5'd1);
        chk("rst_tail", tail, 5'd1);
        chk("rst_full", full, 1'b0);
        chk("rst_commit_valid", commit_valid, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_rs1_ready", rob_rs1_ready, 1'b0);
        nxt();
        rst = 1'b0;

        // fill all 16 entries
        for (int i = 1; i <= 16; i++) begin
            issue_valid = 1; issue_rd_hv = 1; issue_rd = 5'(i);
            @(negedge clk);
            chk($sformatf("fill_tail_%0d", i), tail, 32'(i));
            chk($sformatf("fill_notfull_%0d", i), full, 1'b0);
            nxt();
        end
        issue_rd = 5'd17;
        @(negedge clk);
        chk("full_after_16", full, 1'b1);
        chk("tail_wrapped", tail, 5'd1);
        nxt();
        issue_valid = 0;
        @(negedge clk);
        chk("issue17_ignored_tail", tail, 5'd1);
        chk("issue17_ignored_full", full, 1'b1);

        // drain in order, one CDB write per cycle
        for (int i = 1; i <= 16; i++) begin
            nxt();
            cdb_valid = 1; cdb_tag = 5'(i); cdb_value = 32'h100 + 32'(i);
            issue_valid = (i == 2);
            push(5'(i), 32'h100 + 32'(i), 5'(i), 1'b0, 32'h0);
            @(negedge clk);
            if (i == 1) chk("cdb_head_no_same_cycle_commit", commit_valid, 1'b0);
            if (i == 2) begin
                chk("commit_while_full_valid", commit_valid, 1'b1);
                chk("commit_while_full_full", full, 1'b1);
            end
        end
        nxt();
        cdb_valid = 0; issue_valid = 0;
        for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d commits pending, 0 required", q.size());
        end
        #1;
        @(negedge clk);
        chk("drain_head", head, 5'd1);
        chk("drain_tail", tail, 5'd1);
        chk("drain_full", full, 1'b0);
        nxt();

        // single commit: tag1 rd=5 value 0x1234
        issue_valid = 1; issue_rd_hv = 1; issue_rd = 5'd5;
        @(negedge clk);
        chk("b_tail", tail, 5'd1);
        nxt();
        issue_valid = 0;
        cdb_valid = 1; cdb_tag = 5'd1; cdb_value = 32'h1234;
        push(5'd5, 32'h1234, 5'd1, 1'b0, 32'h0);
        @(negedge clk);
        chk("b_cdb_latency", commit_valid, 1'b0);
        nxt();
        cdb_valid = 0;
        @(negedge clk);
        nxt();

        // mispredicted branch at tag2, younger op at tag3
        issue_valid = 1; issue_rd_hv = 0; issue_is_br = 1; issue_pred_taken = 0;
        @(negedge clk);
        chk("c_br_tail", tail, 5'd2);
        nxt();
        issue_rd_hv = 1; issue_rd = 5'd7; issue_is_br = 0;
        @(negedge clk);
        chk("c_op_tail", tail, 5'd3);
        nxt();
        issue_valid = 0;
        cdb_valid = 1; cdb_tag = 5'd3; cdb_value = 32'h77;
        rs1_id = 5'd3; rs2_id = 5'd0;
        @(negedge clk);
        chk("lookup_same_cycle", rob_rs1_ready, BYP);
        chk("lookup_rs0_ready", rob_rs2_ready, 1'b0);
        chk("lookup_rs0_value", rob_rs2_value, 32'h0);
        nxt();
        cdb_valid = 0;
        @(negedge clk);
        chk("lookup_next_ready", rob_rs1_ready, 1'b1);
        chk("lookup_next_value", rob_rs1_value, 32'h77);
        chk("c_head_not_ready", commit_valid, 1'b0);
        nxt();
        cdb_valid = 1; cdb_tag = 5'd2; cdb_value = 32'h0;
        cdb_br_taken = 1; cdb_br_target = 32'h100;
        push(5'd0, 32'h0, 5'd2, 1'b1, 32'h100);
        @(negedge clk);
        chk("c_br_cdb_latency", commit_valid, 1'b0);
        nxt();
        cdb_valid = 0; cdb_br_taken = 0;
        issue_valid = 1; issue_rd = 5'd9;
        @(negedge clk);
        nxt();
        issue_valid = 0;
        @(negedge clk);
        chk("flush_head", head, 5'd1);
        chk("flush_tail", tail, 5'd1);
        chk("flush_full", full, 1'b0);
        chk("flush_no_commit", commit_valid, 1'b0);
        chk("flush_cleared_lookup", rob_rs1_ready, 1'b0);
        rs1_id = 0;
        nxt();

        // stall with a ready head
        issue_valid = 1; issue_rd = 5'd3;
        @(negedge clk);
        nxt();
        issue_valid = 0;
        cdb_valid = 1; cdb_tag = 5'd1; cdb_value = 32'hABCD;
        push(5'd3, 32'hABCD, 5'd1, 1'b0, 32'h0);
        @(negedge clk);
        nxt();
        cdb_valid = 0; rdy = 0;
        issue_valid = 1; issue_rd = 5'd4;
        @(negedge clk);
        chk("stall_no_commit", commit_valid, 1'b0);
        nxt();
        @(negedge clk);
        chk("stall_head", head, 5'd1);
        chk("stall_tail", tail, 5'd2);
        chk("stall_no_commit2", commit_valid, 1'b0);
        nxt();
        rdy = 1; issue_valid = 0;
        @(negedge clk);
        nxt();
        @(negedge clk);
        chk("resume_head", head, 5'd2);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_commits: got %0d expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter ROB_SZ, default 16, number of reorder entries.
REQ-002 SHALL have parameter TAG_W, default 5, tag width; tag 0 means "no producer"; valid tags 1..ROB_SZ.
REQ-003 SHALL have reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rdy  in  1  global stall; state holds when low.
REQ-007 issue_valid  in  1  decoder presents an instruction.
REQ-008 issue_rd_hv, issue_rd  in  1, 5  destination present and its register index.
REQ-009 issue_is_br, issue_pred_taken  in  1, 1  conditional branch and its predicted direction.
REQ-010 full  out  1  no free entry.
REQ-011 tail  out  TAG_W  tag allocated to the current issue.
REQ-012 cdb_valid, cdb_tag, cdb_value  in  1, TAG_W, 32  execution result broadcast.
REQ-013 cdb_br_taken, cdb_br_target  in  1, 32  resolved branch direction and redirect PC.
REQ-014 rs1_id, rs2_id  in  TAG_W  operand producer tags from the rename table.
REQ-015 rob_rs1_ready/rob_rs1_value, rob_rs2_ready/rob_rs2_value  out  1/32 each  operand lookup result.
REQ-016 commit_valid, commit_rd, commit_value, head  out  1, 5, 32, TAG_W  retirement of the oldest entry.
REQ-017 flush, flush_pc  out  1, 32  mispredict squash and redirect PC.

Function
REQ-018 Each entry SHALL hold: busy, ready, rd_hv, rd, value, is_br, pred_taken, act_taken, target.
REQ-019 Issue SHALL be accepted on a clock edge iff issue_valid && !full && rdy && !flush; the entry at tail gets busy=1, ready=0, and tail advances ROB_SZ->1 wrap.
REQ-020 full SHALL be (count==ROB_SZ); a same-cycle commit does not free the slot for issue.
REQ-021 A CDB write to a busy entry SHALL set ready=1 and store value/act_taken/target; writes to non-busy entries or tag 0 are ignored.
REQ-022 commit_valid SHALL be combinational: busy[head] && ready[head] && rdy; at most one commit per cycle.
REQ-023 commit_rd SHALL equal rd of the head entry when rd_hv, else 0; commit_value = entry value.
REQ-024 On a commit edge head SHALL advance (wrap ROB_SZ->1) and busy is cleared.
REQ-025 Simultaneous issue and commit SHALL leave count unchanged.
REQ-026 flush SHALL be asserted, combinationally, when commit_valid && is_br && act_taken!=pred_taken; flush_pc = target when taken, else PC+4 value from CDB target.
REQ-027 On a flush edge all entries SHALL clear, head=tail=1, count=0; that cycle's issue and CDB writes are discarded.
REQ-028 Lookup: rob_rsN_ready = busy[rs_id] && ready[rs_id], rob_rsN_value = value[rs_id]; rs_id 0 yields ready 0, value 0.
REQ-029 CDB result arriving on the head entry SHALL commit no earlier than the next cycle.

Reset
REQ-030 On rst: head=1, tail=1, count=0, all busy/ready cleared; commit_valid=0, flush=0, full=0, lookup outputs 0.
REQ-031 rst SHALL take priority over rdy, flush, issue and CDB.

Configuration
REQ-032 Macro ROB_CDB_BYPASS_EN defined: lookup SHALL also report ready with cdb_value when cdb_valid && cdb_tag==rs_id in the same cycle.
REQ-033 Macro undefined: lookup reflects stored state only; a same-cycle CDB result becomes visible the next cycle.

Verification
REQ-034 Reset, issue 16 rd_hv instructions -> tails 1..16, full=1 after 16th, 17th issue ignored, tail wraps to 1.
REQ-035 Issue tag1 rd=5, CDB tag1 value 0x1234 -> next cycle commit_valid=1, commit_rd=5, commit_value=0x1234, head=1.
REQ-036 Branch tag2 pred_taken=0, CDB taken=1 target 0x100 -> at commit flush=1, flush_pc=0x100; next cycle head=tail=1, full=0.
REQ-037 CDB tag3 while rs1_id=3 -> with ROB_CDB_BYPASS_EN ready=1 same cycle; without, ready=1 one cycle later.
REQ-038 rdy low during ready head -> commit_valid=0, no state change; resumes commit when rdy returns high.
